// File: rtl/rd_req_pkg.sv
// Shared width helpers and the queued-entry type for the read-request queue.
package rd_req_pkg;

  function automatic int sel_width(input int master_num);
    int w;
    w = $clog2(master_num);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter must hold 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_CNT_W   = $clog2(DEFAULT_DEPTH) + 1;

  virtual class rd_req_types #(parameter int AWIDTH = 32, parameter int MASTER_NUM = 2);
    typedef struct packed {
      logic [AWIDTH-1:0]     addr;
      logic [MASTER_NUM-1:0] wren;
      logic                  dec_err;
    } rd_req_entry_t;
  endclass

endpackage

// File: rtl/rd_req_fifo_ch.sv
// One request channel: show-ahead FIFO with push-time master decode and sticky error flags.
// Optional occupancy port under RD_REQ_LEVEL_EN.
module rd_req_fifo_ch
  import rd_req_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int MASTER_NUM = 2,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  input  logic [AWIDTH-1:0]     s_addr,
  output logic                  s_ready,
  output logic                  req,
  output logic [AWIDTH-1:0]     addr,
  output logic [MASTER_NUM-1:0] wren,
  output logic                  dec_err,
  input  logic                  rd_en,
  output logic                  fifo_full,
  output logic                  afull,
  output logic                  ovf_err,
  output logic                  udf_err
`ifdef RD_REQ_LEVEL_EN
  ,output logic [CW-1:0]        level
`endif
);

  localparam int PW   = CW - 1;
  localparam int SELW = sel_width(MASTER_NUM);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  AFULL_C = CW'(AFULL_LVL);
  localparam logic [SELW:0]  MN_C    = (SELW + 1)'(MASTER_NUM);

  typedef rd_req_types #(.AWIDTH(AWIDTH), .MASTER_NUM(MASTER_NUM))::rd_req_entry_t entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic            full, empty, push, pop;
  logic [SELW-1:0] sel;
  entry_t          push_entry, head;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = s_valid & ~full;
  assign pop   = rd_en & ~empty;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = s_addr;
    sel             = s_addr[AWIDTH-1 -: SELW];
    if ({1'b0, sel} < MN_C) begin
      for (int m = 0; m < MASTER_NUM; m++) push_entry.wren[m] = (sel == SELW'(m));
    end else begin
      push_entry.dec_err = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (s_valid & full);
    udf_d    = udf_q | (rd_en & empty);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge aclk) begin
    if (push && aresetn) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign req       = ~empty;
  assign s_ready   = ~full;
  assign fifo_full = full;
  assign afull     = (cnt_q >= AFULL_C);
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;
  assign addr      = req ? head.addr    : '0;
  assign wren      = req ? head.wren    : '0;
  assign dec_err   = req ? head.dec_err : 1'b0;
`ifdef RD_REQ_LEVEL_EN
  assign level     = cnt_q;
`endif

endmodule

// File: rtl/rd_req_queue.sv
// Multi-channel read-request buffer: CH_NUM independent decode FIFOs feeding the arbiter.
// Define RD_REQ_LEVEL_EN to export per-channel occupancy on port level.
module rd_req_queue
  import rd_req_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int MASTER_NUM = 2,
  parameter int CH_NUM     = 2,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  localparam int LW        = cnt_width(DEPTH)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [CH_NUM-1:0]            s_valid,
  input  logic [CH_NUM*AWIDTH-1:0]     s_addr,
  output logic [CH_NUM-1:0]            s_ready,
  output logic [CH_NUM-1:0]            req,
  output logic [CH_NUM*AWIDTH-1:0]     addr,
  output logic [CH_NUM*MASTER_NUM-1:0] wren,
  output logic [CH_NUM-1:0]            dec_err,
  input  logic [CH_NUM-1:0]            rd_en,
  output logic [CH_NUM-1:0]            fifo_full,
  output logic [CH_NUM-1:0]            afull,
  output logic [CH_NUM-1:0]            ovf_err,
  output logic [CH_NUM-1:0]            udf_err
`ifdef RD_REQ_LEVEL_EN
  ,output logic [CH_NUM*LW-1:0]        level
`endif
);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    rd_req_fifo_ch #(
      .AWIDTH    (AWIDTH),
      .MASTER_NUM(MASTER_NUM),
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
    ) u_ch (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_valid  (s_valid[c]),
      .s_addr   (s_addr[c*AWIDTH +: AWIDTH]),
      .s_ready  (s_ready[c]),
      .req      (req[c]),
      .addr     (addr[c*AWIDTH +: AWIDTH]),
      .wren     (wren[c*MASTER_NUM +: MASTER_NUM]),
      .dec_err  (dec_err[c]),
      .rd_en    (rd_en[c]),
      .fifo_full(fifo_full[c]),
      .afull    (afull[c]),
      .ovf_err  (ovf_err[c]),
      .udf_err  (udf_err[c])
`ifdef RD_REQ_LEVEL_EN
      ,.level   (level[c*LW +: LW])
`endif
    );
  end

endmodule

// File: tb/tb_rd_req_queue.sv
// Scoreboard bench for rd_req_queue: queue-based reference model, decoupled negedge monitor.
module tb_rd_req_queue;

  localparam int AW  = 32;
  localparam int MN  = 3;
  localparam int CH  = 2;
  localparam int DP  = 4;
  localparam int AFL = 3;
  localparam int LW  = 3;

  logic              aclk, aresetn;
  logic [CH-1:0]     s_valid, rd_en;
  logic [CH*AW-1:0]  s_addr;
  logic [CH-1:0]     s_ready, req, dec_err, fifo_full, afull, ovf_err, udf_err;
  logic [CH*AW-1:0]  addr;
  logic [CH*MN-1:0]  wren;
`ifdef RD_REQ_LEVEL_EN
  logic [CH*LW-1:0]  level;
`endif

  rd_req_queue #(.AWIDTH(AW), .MASTER_NUM(MN), .CH_NUM(CH), .DEPTH(DP), .AFULL_LVL(AFL)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_addr(s_addr), .s_ready(s_ready),
    .req(req), .addr(addr), .wren(wren), .dec_err(dec_err), .rd_en(rd_en),
    .fifo_full(fifo_full), .afull(afull), .ovf_err(ovf_err), .udf_err(udf_err)
`ifdef RD_REQ_LEVEL_EN
    , .level(level)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int nchk = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  logic [31:0] mq [CH][$];   // reference contents of each channel, head first
  logic [31:0] sb [CH][$];   // expected results of pops, in pop order
  bit m_ovf [CH];
  bit m_udf [CH];

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s ch%0d: actual=%0h required=%0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // Top two address bits pick the master; value 3 has no master.
  function automatic logic [MN-1:0] exp_wren(input logic [31:0] a);
    int s;
    s = int'(a >> 30);
    return (s < MN) ? MN'(1 << s) : '0;
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return int'(a >> 30) >= MN;
  endfunction

  always @(negedge aclk) begin
    if (aresetn && mon_en) begin
      for (int c = 0; c < CH; c++) begin
        int n;
        logic [31:0] e;
        n = mq[c].size();
        chk("req", c, req[c], n > 0);
        chk("fifo_full", c, fifo_full[c], n == DP);
        chk("afull", c, afull[c], n >= AFL);
        chk("s_ready", c, s_ready[c], n < DP);
        chk("ovf_err", c, ovf_err[c], m_ovf[c]);
        chk("udf_err", c, udf_err[c], m_udf[c]);
`ifdef RD_REQ_LEVEL_EN
        chk("level", c, level[c*LW +: LW], n);
`endif
        if (n == 0) begin
          chk("idle_addr", c, addr[c*AW +: AW], 0);
          chk("idle_wren", c, wren[c*MN +: MN], 0);
          chk("idle_dec_err", c, dec_err[c], 0);
        end
        if (rd_en[c] && req[c]) begin
          if (sb[c].size() == 0) begin
            chk("unexpected_pop", c, 1, 0);
          end else begin
            e = sb[c].pop_front();
            chk("pop_addr", c, addr[c*AW +: AW], e);
            chk("pop_wren", c, wren[c*MN +: MN], exp_wren(e));
            chk("pop_dec_err", c, dec_err[c], exp_err(e));
          end
        end
      end
    end
  end

  // Drive one cycle of inputs, then advance the reference by the effect of that edge.
  task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] r);
    logic [31:0] a [CH];
    bit full [CH];
    bit empty [CH];
    a[0] = a0;
    a[1] = a1;
    s_valid = v;
    rd_en   = r;
    s_addr  = {a1, a0};
    for (int c = 0; c < CH; c++) begin
      full[c]  = (mq[c].size() == DP);
      empty[c] = (mq[c].size() == 0);
      if (r[c] && !empty[c]) sb[c].push_back(mq[c][0]);
    end
    @(posedge aclk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (r[c] && !empty[c]) void'(mq[c].pop_front());
      if (v[c] && full[c]) m_ovf[c] = 1'b1;
      if (r[c] && empty[c]) m_udf[c] = 1'b1;
      if (v[c] && !full[c]) mq[c].push_back(a[c]);
    end
    s_valid = '0;
    rd_en   = '0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      sb[c].delete();
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_req", 0, req, 0);
    chk("rst_s_ready", 0, s_ready, 2'b11);
    chk("rst_full", 0, fifo_full, 0);
    chk("rst_afull", 0, afull, 0);
    chk("rst_ovf", 0, ovf_err, 0);
    chk("rst_udf", 0, udf_err, 0);
    chk("rst_addr", 0, addr, 0);
    chk("rst_wren", 0, wren, 0);
    chk("rst_dec_err", 0, dec_err, 0);
  endtask

  initial begin
    logic [31:0] x;
    model_clear();
    aresetn = 1'b0;
    s_valid = 2'b11;
    rd_en   = 2'b11;
    s_addr  = {32'h1234_5678, 32'h8765_4321};
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_state();
    aresetn = 1'b1;
    s_valid = '0;
    rd_en   = '0;
    mon_en  = 1'b1;
    cycle(2'b00, 0, 0, 2'b00);

    // master decode on ch0, then pop in order
    cycle(2'b01, 32'h0000_0010, 0, 2'b00);
    cycle(2'b01, 32'h8000_0000, 0, 2'b00);
    cycle(2'b01, 32'hC000_0000, 0, 2'b00);
    cycle(2'b01, 32'h4000_0abc, 0, 2'b01);
    repeat (3) cycle(2'b00, 0, 0, 2'b01);

    // fill ch1 past full, then drain
    for (int i = 0; i < 5; i++) cycle(2'b10, 0, 32'h100 + i, 2'b00);
    repeat (4) cycle(2'b00, 0, 0, 2'b10);

    // full with push+pop, then empty with push+pop
    for (int i = 0; i < 4; i++) cycle(2'b10, 0, 32'hC000_0200 + i, 2'b00);
    cycle(2'b10, 0, 32'h0000_DEAD, 2'b10);
    repeat (3) cycle(2'b00, 0, 0, 2'b10);
    cycle(2'b10, 0, 32'h8000_BEEF, 2'b10);
    cycle(2'b00, 0, 0, 2'b10);

    // streaming on ch0 across pointer wrap with ch1 idle
    cycle(2'b01, $urandom, 0, 2'b00);
    for (int i = 0; i < 20; i++) cycle(2'b01, $urandom, 0, 2'b01);
    cycle(2'b00, 0, 0, 2'b01);

    // asynchronous reset with entries queued on ch1
    cycle(2'b10, 0, 32'h0000_0111, 2'b00);
    cycle(2'b10, 0, 32'h4000_0222, 2'b00);
    #2;
    aresetn = 1'b0;
    s_valid = 2'b11;
    rd_en   = 2'b11;
    #1;
    chk_reset_state();
    model_clear();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    s_valid = '0;
    rd_en   = '0;
    cycle(2'b10, 0, 32'h8000_AAAA, 2'b00);
    cycle(2'b00, 0, 0, 2'b10);
    cycle(2'b00, 0, 0, 2'b00);

    // randomized traffic on both channels
    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      cycle(2'($urandom), x, $urandom, 2'($urandom));
    end
    repeat (DP + 1) cycle(2'b00, 0, 0, 2'b11);
    for (int c = 0; c < CH; c++) chk("sb_drained", c, sb[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
